// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host transmitter types, error codes and keyboard command constants.
package ps2_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INHIBIT   = 4'd1,
    S_RTS       = 4'd2,
    S_DATA      = 4'd3,
    S_STOP      = 4'd4,
    S_ACK       = 4'd5,
    S_WAIT_IDLE = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } tx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_ACK_RESP = 8'hFA;

  // PS/2 frames carry odd parity: the parity bit makes the 9-bit total odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronisers for PS2_CLK/PS2_DAT, a stable-level glitch filter on the
// clock and a one-cycle pulse on each filtered falling edge. Also used by ps2_keyboard.
module ps2_line_sync #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic fall_o
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    clk_meta_q;
  logic [1:0]    dat_meta_q;
  logic          clk_filt_q;
  logic          fall_q;
  logic [CW-1:0] flt_cnt_q;

  // Synchronisers reset to the idle (released, high) bus level.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      clk_meta_q <= 2'b11;
      dat_meta_q <= 2'b11;
    end else begin
      clk_meta_q <= {clk_meta_q[0], ps2_clk_i};
      dat_meta_q <= {dat_meta_q[0], ps2_dat_i};
    end
  end

  // The filtered clock only follows after FILTER_LEN consecutive cycles at the new level.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      flt_cnt_q  <= '0;
      clk_filt_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_meta_q[1] == clk_filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == CNT_LAST) begin
        flt_cnt_q  <= '0;
        clk_filt_q <= clk_meta_q[1];
        fall_q     <= clk_filt_q;
      end else begin
        flt_cnt_q <= flt_cnt_q + CW'(1);
      end
    end
  end

  assign clk_sync_o = clk_meta_q[1];
  assign dat_sync_o = dat_meta_q[1];
  assign fall_o     = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain CLK/DAT enables.
// Define PS2_TX_TIMEOUT_EN to add the per-phase watchdog (err_code 10 on expiry).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750_000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST      = IW'(INHIBIT_CYCLES - 1);
  localparam logic [IW-1:0] INH_START_BIT = IW'(INHIBIT_CYCLES - 2);

  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || FILTER_LEN < 1 || CLK_HZ == 0) begin : g_bad_params
    $error("ps2_host_tx: parameter out of range");
  end

  tx_state_e     state_q;
  logic [8:0]    shift_q;
  logic [3:0]    bit_cnt_q;
  logic [IW-1:0] inh_cnt_q;
  logic          tx_ready_q;
  logic          tx_busy_q;
  logic          tx_done_q;
  logic          tx_err_q;
  logic [1:0]    err_code_q;
  logic          clk_oe_q;
  logic          dat_oe_q;

  logic clk_sync_s;
  logic dat_sync_s;
  logic fall_s;

  ps2_line_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_sync (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .ps2_clk_i (ps2_clk_in),
    .ps2_dat_i (ps2_dat_in),
    .clk_sync_o(clk_sync_s),
    .dat_sync_o(dat_sync_s),
    .fall_o    (fall_s)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  logic [WW-1:0] wd_q;
  logic          watch_s;
  logic          timeout_s;

  always_comb begin
    watch_s = 1'b0;
    case (state_q)
      S_RTS, S_DATA, S_STOP, S_ACK, S_WAIT_IDLE: watch_s = 1'b1;
      default:                                   watch_s = 1'b0;
    endcase
  end

  assign timeout_s = watch_s & ~fall_s & (wd_q == WD_LAST);

  // Held at zero outside the device-clocked phases, so it restarts on RTS entry and every fall.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (!watch_s || fall_s) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + WW'(1);
    end
  end
`endif

  // Transmit sequencer; every bus-facing output is a register updated here.
  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= 4'd0;
      inh_cnt_q  <= '0;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
      dat_oe_q   <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      if (timeout_s) begin
        clk_oe_q   <= 1'b0;
        dat_oe_q   <= 1'b0;
        err_code_q <= ERR_TIMEOUT;
        tx_err_q   <= 1'b1;
        state_q    <= S_ERR;
      end else
`endif
      begin
        case (state_q)
          S_IDLE: begin
            if (tx_valid) begin
              shift_q    <= {odd_parity(tx_data), tx_data};
              err_code_q <= ERR_NONE;
              inh_cnt_q  <= '0;
              bit_cnt_q  <= 4'd0;
              clk_oe_q   <= 1'b1;
              tx_ready_q <= 1'b0;
              tx_busy_q  <= 1'b1;
              state_q    <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            inh_cnt_q <= inh_cnt_q + IW'(1);
            if (inh_cnt_q == INH_LAST) begin
              clk_oe_q <= 1'b0;
              state_q  <= S_RTS;
            end else if (inh_cnt_q == INH_START_BIT) begin
              dat_oe_q <= 1'b1;
            end
          end
          S_RTS: begin
            if (fall_s) begin
              dat_oe_q  <= ~shift_q[0];
              shift_q   <= {1'b0, shift_q[8:1]};
              bit_cnt_q <= 4'd1;
              state_q   <= S_DATA;
            end
          end
          S_DATA: begin
            // Falls #2..#9 carry data bits 1..7 and then the parity bit.
            if (fall_s) begin
              dat_oe_q  <= ~shift_q[0];
              shift_q   <= {1'b0, shift_q[8:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd8) begin
                state_q <= S_STOP;
              end
            end
          end
          S_STOP: begin
            if (fall_s) begin
              dat_oe_q  <= 1'b0;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              state_q   <= S_ACK;
            end
          end
          S_ACK: begin
            if (fall_s) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (!dat_sync_s) begin
                state_q <= S_WAIT_IDLE;
              end else begin
                clk_oe_q   <= 1'b0;
                dat_oe_q   <= 1'b0;
                err_code_q <= ERR_NACK;
                tx_err_q   <= 1'b1;
                state_q    <= S_ERR;
              end
            end
          end
          S_WAIT_IDLE: begin
            if (clk_sync_s && dat_sync_s) begin
              tx_done_q <= 1'b1;
              state_q   <= S_DONE;
            end
          end
          S_DONE, S_ERR: begin
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            state_q    <= S_IDLE;
          end
          default: begin
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            tx_ready_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            state_q    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready   = tx_ready_q;
  assign tx_busy    = tx_busy_q;
  assign tx_done    = tx_done_q;
  assign tx_err     = tx_err_q;
  assign err_code   = err_code_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx against a behavioural PS/2 device and a frame model.
// The timeout scenario is exercised only when PS2_TX_TIMEOUT_EN is defined.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 5000;
  localparam int unsigned TMO = 3000;
  localparam int HP = 25;

  localparam int M_NORM   = 0;
  localparam int M_NACK   = 1;
  localparam int M_GLITCH = 2;
  localparam int M_IGNORE = 3;
  localparam int M_RST    = 4;

  logic       CLOCK_50 = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_busy, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
  logic       dev_clk_rel;
  logic       dev_dat_low;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int wide_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  // Open-drain wired-AND of host and device on each line.
  assign ps2_clk_in = ~ps2_clk_oe & dev_clk_rel;
  assign ps2_dat_in = ~ps2_dat_oe & ~dev_dat_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (8)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err),
    .err_code  (err_code),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "tb_ps2_host_tx stalled");
  end

  always @(negedge CLOCK_50) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if ((tx_done && prev_done) || (tx_err && prev_err)) wide_cnt <= wide_cnt + 1;
    prev_done <= tx_done;
    prev_err  <= tx_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Expected 11-bit frame as seen by the device: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_model(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic send_start(input logic [7:0] b);
    int cnt;
    int rise;
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check_eq($sformatf("capture_%02h", b), {29'd0, tx_ready, tx_busy, ps2_clk_oe}, 32'd3);
    cnt  = 0;
    rise = 0;
    while (ps2_clk_oe && cnt < int'(INH) + 100) begin
      cnt++;
      if (ps2_dat_oe && rise == 0) rise = cnt;
      tick(1);
    end
    check_eq($sformatf("inhibit_len_%02h", b), cnt, INH);
    check_eq($sformatf("start_bit_cycle_%02h", b), rise, INH);
  endtask

  task automatic device_frame(input int mode, output logic [10:0] seen);
    int w;
    w = 0;
    seen = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 20000) begin
      tick(1);
      w++;
    end
    check_eq("rts_reached", (w < 20000) ? 32'd1 : 32'd0, 32'd1);
    tick(50);
    if (mode == M_GLITCH) begin
      dev_clk_rel = 1'b0;
      tick(3);
      dev_clk_rel = 1'b1;
      tick(30);
      check_eq("glitch_ignored", {31'd0, ps2_dat_oe}, 32'd1);
    end
    seen[0] = ps2_dat_in;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && mode != M_NACK) dev_dat_low = 1'b1;
      dev_clk_rel = 1'b0;
      if (k == 4 && mode == M_IGNORE) begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
      end
      if (k == 6 && mode == M_IGNORE) tx_valid = 1'b0;
      if (k == 4 && mode == M_RST) begin
        tick(HP - 5);
        check_eq("pre_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("rst_release_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        tick(1);
        rst = 1'b0;
        dev_clk_rel = 1'b1;
        dev_dat_low = 1'b0;
        tick(20);
        return;
      end
      tick(HP);
      dev_clk_rel = 1'b1;
      if (k <= 10) seen[k] = ps2_dat_in;
      tick(HP);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input int mode);
    logic [10:0] seen;
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_start(b);
    device_frame(mode, seen);
    tick(10);
    if (mode == M_RST) begin
      check_eq("rst_ready", {30'd0, tx_ready, tx_busy}, 32'd2);
      check_eq("rst_no_pulse", done_cnt - d0 + err_cnt - e0, 32'd0);
    end else begin
      check_eq($sformatf("bits_%02h", b), {21'd0, seen}, {21'd0, frame_model(b)});
      check_eq($sformatf("done_%02h", b), done_cnt - d0, (mode == M_NACK) ? 32'd0 : 32'd1);
      check_eq($sformatf("err_%02h", b), err_cnt - e0, (mode == M_NACK) ? 32'd1 : 32'd0);
      check_eq($sformatf("err_code_%02h", b), {30'd0, err_code},
               {30'd0, (mode == M_NACK) ? ERR_NACK : ERR_NONE});
      check_eq($sformatf("end_state_%02h", b),
               {28'd0, tx_ready, tx_busy, ps2_clk_oe, ps2_dat_oe}, 32'd8);
    end
  endtask

  initial begin
    logic [7:0] b;
    int n;
    rst         = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    dev_clk_rel = 1'b1;
    dev_dat_low = 1'b0;
    tick(3);
    check_eq("reset_outputs",
             {24'd0, tx_ready, tx_busy, tx_done, tx_err, err_code, ps2_clk_oe, ps2_dat_oe},
             32'h80);
    rst = 1'b0;
    tick(20);
    check_eq("idle_ready", {31'd0, tx_ready}, 32'd1);

    run_frame(CMD_SET_LEDS, M_NORM);
    run_frame(CMD_ENABLE, M_NORM);
    run_frame(CMD_RESET, M_NACK);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    send_start(CMD_ENABLE);
    while (!tx_err && n < int'(TMO) + 100) begin
      tick(1);
      n++;
    end
    check_eq("timeout_cycles", n, TMO);
    tick(5);
    check_eq("timeout_code", {30'd0, err_code}, {30'd0, ERR_TIMEOUT});
    check_eq("timeout_lines", {29'd0, tx_ready, ps2_clk_oe, ps2_dat_oe}, 32'd4);
`else
    n = 0;
    check_eq("err_code_b1", {30'd0, err_code & ERR_TIMEOUT}, 32'd0 + n);
`endif
    run_frame(CMD_RESET, M_IGNORE);
    tick(50);
    check_eq("ignored_valid", {30'd0, tx_ready, ps2_clk_oe}, 32'd2);
    run_frame(8'h00, M_RST);
    run_frame(CMD_RESET, M_NORM);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == CMD_ACK_RESP) b = b ^ 8'h01;
      run_frame(b, (i % 2 == 1) ? M_GLITCH : M_NORM);
    end
    check_eq("pulse_width", wide_cnt, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
